text_console_writer: RTL
========================

Name: text_console_writer

Overview:
- Writer side of the character RAM that the VGA text pipeline reads: converts a byte stream (e.g. from a UART receiver) into RAM write-port cycles.
- Keeps a cursor, interprets a small set of control codes, and performs line and screen clears with space characters.
- Output drives the RAM write port on the pixel clock domain: wr_en / waddr / wdata.
- RAM address layout is {row, col}, matching the reader's addressing.

Parameters:
- COLS, 16, characters per row; must be a power of two.
- ROWS, 8, text rows; must be a power of two.
- COL_W, 4, log2(COLS).
- ROW_W, 3, log2(ROWS).
- SPACE, 8'h20, fill code written by clears.

Ports:
- clk  input  1  system/pixel clock; every register is on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  8  byte to display.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a byte this cycle; high only in IDLE.
- wr_en  output  1  RAM write strobe (registered).
- waddr  output  ROW_W+COL_W  RAM write address {row, col} (registered).
- wdata  output  8  RAM write data (registered).
- cursor_x  output  COL_W  current column.
- cursor_y  output  ROW_W  current row.
- busy  output  1  a clear is in progress; equals !in_ready.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state=INIT_CLR, clr_cnt=0, wr_en=0, waddr=0, wdata=0, cursor_x=0, cursor_y=0. Therefore in_ready=0 and busy=1 during and immediately after reset.
- Handshake: a byte is accepted on a rising edge where in_valid && in_ready. in_data need only be stable in that cycle. There is no buffering; the producer holds in_valid until ready.
- wr_en is high for exactly one cycle per write. On cycles with no write, wr_en=0, and waddr/wdata hold their last value.
- INIT_CLR:
  - Writes SPACE to addresses 0..ROWS*COLS-1, one per cycle, in ascending order.
  - Default parameters: 128 writes on the first 128 edges after reset release.
  - After the write to the last address, the next state is IDLE.
- IDLE: handles each accepted byte b as follows.
  - b >= 0x20 (including 0x80–0xFF):
    - At the accept edge: wr_en=1, waddr={cursor_y, cursor_x}, wdata=b. Latency is 1 edge.
    - If cursor_x < COLS-1: cursor_x+1 and stay in IDLE.
    - Otherwise (wrap): cursor_x=0, cursor_y=(cursor_y+1) mod ROWS, go to LINE_CLR.
  - 0x0A LF: no write. cursor_x=0, cursor_y=(cursor_y+1) mod ROWS, go to LINE_CLR.
  - 0x0D CR: no write, cursor_x=0, stay in IDLE.
  - 0x08 BS: no write. If cursor_x > 0, cursor_x-1; at column 0, no change. Stay in IDLE.
  - 0x0C FF: no write, cursor_x=0, cursor_y=0, go to FULL_CLR.
  - Any other 0x00–0x1F: consumed and ignored, no write, no cursor change.
- LINE_CLR:
  - clr_cnt runs 0..COLS-1; each edge writes waddr={cursor_y, clr_cnt}, wdata=SPACE.
  - COLS writes in total (16 by default), then IDLE.
  - in_ready=0 throughout; cursor is stable.
- FULL_CLR: identical to INIT_CLR (ROWS*COLS writes of SPACE from address 0), then IDLE.
- Wrap-around:
  - The row index wraps from ROWS-1 to 0. There is no scrolling.
  - The destination row is always cleared before new text is accepted.
- Reset mid-operation: any state returns asynchronously to INIT_CLR with all counters at 0. Any in-progress clear restarts from address 0.
- Simultaneous events: an in_valid asserted during a clear is not accepted and not lost; it is taken on the first IDLE cycle.
- Throughput: one printable byte per clock while no wrap occurs.

Test Plan:
- Reset release with in_valid=0 -> exactly 128 wr_en pulses, waddr 0x00..0x7F ascending, wdata=0x20; then in_ready=1, cursor (0,0).
- After init, send 'A' (0x41) -> next edge wr_en=1, waddr=0x00, wdata=0x41; cursor_x=1, in_ready stays 1.
- Send 16 printable bytes 0x30..0x3F from (0,0):
  - Writes go to 0x00..0x0F.
  - Then 16 SPACE writes to 0x10..0x1F with in_ready=0.
  - Cursor ends at (0,1).
- With cursor at row 7 col 5, send LF -> no char write; cursor (0,0); 16 SPACE writes to 0x00..0x0F; then IDLE.
- Send BS at col 0 -> no write, cursor unchanged. Send "AB" then BS -> cursor_x=1. Send CR -> cursor_x=0. Send 0x07 -> consumed, no write.
- Send FF from (3,2) -> 128 SPACE writes, cursor (0,0). Assert rst at the 40th write -> wr_en=0 immediately; after release, a full 128-write init from 0x00.

Source files
------------

// File: rtl/text_console_writer.sv
// Byte-stream to character-RAM writer: tracks a cursor, interprets control
// codes and clears lines or the whole screen with SPACE.
module text_console_writer #(
    parameter int unsigned COLS  = 16,
    parameter int unsigned ROWS  = 8,
    parameter int unsigned COL_W = 4,
    parameter int unsigned ROW_W = 3,
    parameter logic [7:0]  SPACE = 8'h20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   wr_en,
    output logic [ROW_W+COL_W-1:0] waddr,
    output logic [7:0]             wdata,
    output logic [COL_W-1:0]       cursor_x,
    output logic [ROW_W-1:0]       cursor_y,
    output logic                   busy
);

    localparam int unsigned AW = ROW_W + COL_W;

    typedef enum logic [1:0] {
        S_INIT_CLR,
        S_IDLE,
        S_LINE_CLR,
        S_FULL_CLR
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [AW-1:0]    r_clr_cnt, w_clr_cnt_nxt;
    logic             r_wr_en, w_wr_en_nxt;
    logic [AW-1:0]    r_waddr, w_waddr_nxt;
    logic [7:0]       r_wdata, w_wdata_nxt;
    logic [COL_W-1:0] r_cx, w_cx_nxt;
    logic [ROW_W-1:0] r_cy, w_cy_nxt;
    logic             w_accept;
    logic             w_full_done;
    logic             w_line_done;

    assign w_accept    = in_valid && (r_state == S_IDLE);
    assign w_full_done = (r_clr_cnt == AW'(ROWS * COLS - 1));
    assign w_line_done = (r_clr_cnt[COL_W-1:0] == COL_W'(COLS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_INIT_CLR;
            r_clr_cnt <= '0;
            r_wr_en   <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_cx      <= '0;
            r_cy      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_waddr   <= w_waddr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_cx      <= w_cx_nxt;
            r_cy      <= w_cy_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_wr_en_nxt   = 1'b0;
        w_waddr_nxt   = r_waddr;
        w_wdata_nxt   = r_wdata;
        w_cx_nxt      = r_cx;
        w_cy_nxt      = r_cy;

        unique case (r_state)
            S_INIT_CLR, S_FULL_CLR: begin
                w_wr_en_nxt = 1'b1;
                w_waddr_nxt = r_clr_cnt;
                w_wdata_nxt = SPACE;
                if (w_full_done) begin
                    w_clr_cnt_nxt = '0;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + AW'(1);
                end
            end

            S_LINE_CLR: begin
                w_wr_en_nxt = 1'b1;
                w_waddr_nxt = {r_cy, r_clr_cnt[COL_W-1:0]};
                w_wdata_nxt = SPACE;
                if (w_line_done) begin
                    w_clr_cnt_nxt = '0;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + AW'(1);
                end
            end

            S_IDLE: begin
                if (w_accept) begin
                    if (in_data >= 8'h20) begin
                        w_wr_en_nxt = 1'b1;
                        w_waddr_nxt = {r_cy, r_cx};
                        w_wdata_nxt = in_data;
                        if (r_cx != COL_W'(COLS - 1)) begin
                            w_cx_nxt = r_cx + COL_W'(1);
                        end else begin
                            w_cx_nxt    = '0;
                            w_cy_nxt    = r_cy + ROW_W'(1);
                            w_state_nxt = S_LINE_CLR;
                        end
                    end else begin
                        case (in_data)
                            8'h0A: begin
                                w_cx_nxt    = '0;
                                w_cy_nxt    = r_cy + ROW_W'(1);
                                w_state_nxt = S_LINE_CLR;
                            end
                            8'h0D: w_cx_nxt = '0;
                            8'h08: begin
                                if (r_cx != '0) begin
                                    w_cx_nxt = r_cx - COL_W'(1);
                                end
                            end
                            8'h0C: begin
                                w_cx_nxt    = '0;
                                w_cy_nxt    = '0;
                                w_state_nxt = S_FULL_CLR;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            default: w_state_nxt = S_INIT_CLR;
        endcase
    end

    assign in_ready = (r_state == S_IDLE);
    assign busy     = !in_ready;
    assign wr_en    = r_wr_en;
    assign waddr    = r_waddr;
    assign wdata    = r_wdata;
    assign cursor_x = r_cx;
    assign cursor_y = r_cy;

endmodule
